// File: rtl/modrm_pkg.sv
//------------------------------------------------------------------------------
// Module      : modrm_pkg
// Description : Shared types and ModR/M field constants for the operand decoder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package modrm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MODRM = 3'd1,
    ST_SIB   = 3'd2,
    ST_DISP  = 3'd3,
    ST_CALC  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] ES = 2'd0;
  localparam logic [1:0] CS = 2'd1;
  localparam logic [1:0] SS = 2'd2;
  localparam logic [1:0] DS = 2'd3;

  localparam logic [1:0] MOD_REG     = 2'b11;
  localparam logic [2:0] RM_SIB      = 3'b100;
  localparam logic [2:0] RM_DISP32   = 3'b101;
  localparam logic [2:0] RM16_DIRECT = 3'b110;

  // Register-file numbering shared by the 16- and 32-bit views.
  localparam logic [2:0] REG_BX = 3'd3;
  localparam logic [2:0] REG_SP = 3'd4;
  localparam logic [2:0] REG_BP = 3'd5;
  localparam logic [2:0] REG_SI = 3'd6;
  localparam logic [2:0] REG_DI = 3'd7;

  function automatic logic uses_ss(input logic mode32, input logic [2:0] base);
    return mode32 ? ((base == REG_SP) || (base == REG_BP)) : (base == REG_BP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/modrm_ea_calc.sv
//------------------------------------------------------------------------------
// Module      : modrm_ea_calc
// Description : Combinational ModR/M/SIB field decode and effective-address adder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module modrm_ea_calc
  import modrm_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  mode32,
  input  logic [7:0]            modrm,
  input  logic [7:0]            sib,
  input  logic [31:0]           disp,
  input  logic [ADDR_WIDTH-1:0] base_val,
  input  logic [ADDR_WIDTH-1:0] index_val,
  output logic                  need_sib,
  output logic [2:0]            disp_bytes,
  output logic [2:0]            base_sel,
  output logic [2:0]            index_sel,
  output logic [1:0]            default_seg,
  output logic [ADDR_WIDTH-1:0] ea
);

  logic [1:0]  w_mod;
  logic [2:0]  w_rm;
  logic        w_is_reg;
  logic        w_mode32;
  logic        w_has_base;
  logic [2:0]  w_base16;
  logic [2:0]  w_index16;
  logic        w_has_base16;
  logic        w_has_index16;
  logic [2:0]  w_disp16_len;
  logic [15:0] w_disp16;
  logic [15:0] w_ea16;

  assign w_mod    = modrm[7:6];
  assign w_rm     = modrm[2:0];
  assign w_is_reg = (w_mod == MOD_REG);

  always_comb begin
    w_base16      = REG_BX;
    w_index16     = REG_SI;
    w_has_base16  = 1'b1;
    w_has_index16 = 1'b0;
    case (w_rm)
      3'b000: begin w_base16 = REG_BX; w_index16 = REG_SI; w_has_index16 = 1'b1; end
      3'b001: begin w_base16 = REG_BX; w_index16 = REG_DI; w_has_index16 = 1'b1; end
      3'b010: begin w_base16 = REG_BP; w_index16 = REG_SI; w_has_index16 = 1'b1; end
      3'b011: begin w_base16 = REG_BP; w_index16 = REG_DI; w_has_index16 = 1'b1; end
      3'b100: w_base16 = REG_SI;
      3'b101: w_base16 = REG_DI;
      3'b110: begin w_base16 = REG_BP; w_has_base16 = (w_mod != 2'b00); end
      default: w_base16 = REG_BX;
    endcase
    if (w_is_reg) begin
      w_has_base16  = 1'b0;
      w_has_index16 = 1'b0;
    end
    case (w_mod)
      2'b00:   w_disp16_len = (w_rm == RM16_DIRECT) ? 3'd2 : 3'd0;
      2'b01:   w_disp16_len = 3'd1;
      2'b10:   w_disp16_len = 3'd2;
      default: w_disp16_len = 3'd0;
    endcase
  end

  assign w_disp16 = (w_disp16_len == 3'd1) ? {{8{disp[7]}}, disp[7:0]} : disp[15:0];
  assign w_ea16   = (w_has_base16  ? base_val[15:0]  : 16'd0)
                  + (w_has_index16 ? index_val[15:0] : 16'd0)
                  + w_disp16;

  generate
    if (ADDR_WIDTH == 32) begin : g_addr32
      logic        w_sib32;
      logic [2:0]  w_base32;
      logic        w_has_base32;
      logic        w_has_index32;
      logic [1:0]  w_ss;
      logic [2:0]  w_disp32_len;
      logic [31:0] w_disp32;
      logic [31:0] w_ea32;

      // A base field of 101 with mod 00 means "no base, disp32" both in
      // the rm field and in the SIB base field.
      always_comb begin
        w_sib32       = !w_is_reg && (w_rm == RM_SIB);
        w_base32      = w_sib32 ? sib[2:0] : w_rm;
        w_has_base32  = !w_is_reg && !((w_mod == 2'b00) && (w_base32 == RM_DISP32));
        w_has_index32 = w_sib32 && (sib[5:3] != RM_SIB);
        w_ss          = w_sib32 ? sib[7:6] : 2'b00;
        case (w_mod)
          2'b00:   w_disp32_len = (w_base32 == RM_DISP32) ? 3'd4 : 3'd0;
          2'b01:   w_disp32_len = 3'd1;
          2'b10:   w_disp32_len = 3'd4;
          default: w_disp32_len = 3'd0;
        endcase
      end

      assign w_disp32 = (w_disp32_len == 3'd1) ? {{24{disp[7]}}, disp[7:0]} : disp;
      assign w_ea32   = (w_has_base32  ? base_val            : 32'd0)
                      + (w_has_index32 ? (index_val << w_ss) : 32'd0)
                      + w_disp32;

      assign w_mode32   = mode32;
      assign need_sib   = mode32 & w_sib32;
      assign disp_bytes = mode32 ? w_disp32_len  : w_disp16_len;
      assign base_sel   = mode32 ? w_base32      : w_base16;
      assign index_sel  = mode32 ? sib[5:3]      : w_index16;
      assign w_has_base = mode32 ? w_has_base32  : w_has_base16;
      assign ea         = mode32 ? w_ea32 : {{(ADDR_WIDTH-16){1'b0}}, w_ea16};
    end else begin : g_addr16
      logic w_unused;
      assign w_unused   = ^{mode32, sib, disp[31:16]};
      assign w_mode32   = 1'b0;
      assign need_sib   = 1'b0;
      assign disp_bytes = w_disp16_len;
      assign base_sel   = w_base16;
      assign index_sel  = w_index16;
      assign w_has_base = w_has_base16;
      assign ea         = w_ea16;
    end
  endgenerate

  assign default_seg = (w_has_base && uses_ss(w_mode32, base_sel)) ? SS : DS;

endmodule

`default_nettype wire

// File: rtl/modrm_decoder.sv
//------------------------------------------------------------------------------
// Module      : modrm_decoder
// Description : ModR/M + SIB + displacement fetch FSM producing operand address.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module modrm_decoder
  import modrm_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic                  addr32,
  output logic                  busy,
  output logic                  complete,
  output logic [ADDR_WIDTH-1:0] effective_address,
  output logic [2:0]            regnum,
  output logic                  rm_is_reg,
  output logic [2:0]            rm_regnum,
  output logic [1:0]            default_seg,
  output logic [2:0]            bytes_consumed,
  output logic [2:0]            base_sel,
  output logic [2:0]            index_sel,
  input  logic [ADDR_WIDTH-1:0] base_val,
  input  logic [ADDR_WIDTH-1:0] index_val,
  output logic                  fifo_rd_en,
  input  logic [7:0]            fifo_rd_data,
  input  logic                  fifo_empty
);

  state_t      r_state;
  logic        r_mode32;
  logic [7:0]  r_modrm;
  logic [7:0]  r_sib;
  logic [31:0] r_disp;
  logic [2:0]  r_disp_idx;
  logic [2:0]  r_count;

  logic [7:0]            w_modrm;
  logic [7:0]            w_sib;
  logic                  w_need_sib;
  logic [2:0]            w_disp_bytes;
  logic [2:0]            w_base_sel;
  logic [2:0]            w_index_sel;
  logic [1:0]            w_default_seg;
  logic [ADDR_WIDTH-1:0] w_ea;
  logic                  w_in_fetch;
  logic                  w_pop;
  logic                  w_last;

  // Decode looks at the byte being popped so the next state is known at once.
  assign w_modrm = (r_state == ST_MODRM) ? fifo_rd_data : r_modrm;
  assign w_sib   = (r_state == ST_SIB)   ? fifo_rd_data : r_sib;

  modrm_ea_calc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ea_calc (
    .mode32      (r_mode32),
    .modrm       (w_modrm),
    .sib         (w_sib),
    .disp        (r_disp),
    .base_val    (base_val),
    .index_val   (index_val),
    .need_sib    (w_need_sib),
    .disp_bytes  (w_disp_bytes),
    .base_sel    (w_base_sel),
    .index_sel   (w_index_sel),
    .default_seg (w_default_seg),
    .ea          (w_ea)
  );

  assign w_in_fetch = (r_state == ST_MODRM) || (r_state == ST_SIB) || (r_state == ST_DISP);
  assign w_pop      = w_in_fetch & ~fifo_empty & ~flush & ~reset;
  assign w_last     = w_pop & (((r_state == ST_MODRM) && !w_need_sib && (w_disp_bytes == 3'd0))
                            || ((r_state == ST_SIB)  && (w_disp_bytes == 3'd0))
                            || ((r_state == ST_DISP) && ((r_disp_idx + 3'd1) == w_disp_bytes)));

  assign fifo_rd_en = w_pop;
  assign busy       = (r_state != ST_IDLE);
  assign complete   = (r_state == ST_DONE) & ~reset & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= ST_IDLE;
      r_mode32          <= 1'b0;
      r_modrm           <= 8'd0;
      r_sib             <= 8'd0;
      r_disp            <= 32'd0;
      r_disp_idx        <= 3'd0;
      r_count           <= 3'd0;
      effective_address <= '0;
      regnum            <= 3'd0;
      rm_is_reg         <= 1'b0;
      rm_regnum         <= 3'd0;
      default_seg       <= DS;
      bytes_consumed    <= 3'd0;
      base_sel          <= 3'd0;
      index_sel         <= 3'd0;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      if (w_last) begin
        base_sel  <= w_base_sel;
        index_sel <= w_index_sel;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode32   <= addr32 & (ADDR_WIDTH == 32);
            r_sib      <= 8'd0;
            r_disp     <= 32'd0;
            r_disp_idx <= 3'd0;
            r_count    <= 3'd0;
            r_state    <= ST_MODRM;
          end
        end
        ST_MODRM: begin
          if (w_pop) begin
            r_modrm <= fifo_rd_data;
            r_count <= 3'd1;
            if (w_need_sib)                r_state <= ST_SIB;
            else if (w_disp_bytes != 3'd0) r_state <= ST_DISP;
            else                           r_state <= ST_CALC;
          end
        end
        ST_SIB: begin
          if (w_pop) begin
            r_sib   <= fifo_rd_data;
            r_count <= r_count + 3'd1;
            r_state <= (w_disp_bytes != 3'd0) ? ST_DISP : ST_CALC;
          end
        end
        ST_DISP: begin
          if (w_pop) begin
            r_disp[{r_disp_idx[1:0], 3'b000} +: 8] <= fifo_rd_data;
            r_disp_idx <= r_disp_idx + 3'd1;
            r_count    <= r_count + 3'd1;
            if (w_last) r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          // A register operand has no memory address; the decode already
          // yields no base/index/disp, the explicit override keeps it obvious.
          rm_is_reg         <= (r_modrm[7:6] == MOD_REG);
          effective_address <= (r_modrm[7:6] == MOD_REG) ? '0 : w_ea;
          default_seg       <= (r_modrm[7:6] == MOD_REG) ? DS : w_default_seg;
          regnum            <= r_modrm[5:3];
          rm_regnum         <= r_modrm[2:0];
          bytes_consumed    <= r_count;
          r_state           <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_modrm_decoder.sv
//------------------------------------------------------------------------------
// Module      : tb_modrm_decoder
// Description : Self-checking bench for modrm_decoder (ADDR_WIDTH=32, both modes).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_modrm_decoder;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset, start, flush, addr32;
  logic          busy, complete, rm_is_reg, fifo_rd_en, fifo_empty;
  logic [AW-1:0] effective_address, base_val, index_val;
  logic [2:0]    regnum, rm_regnum, bytes_consumed, base_sel, index_sel;
  logic [1:0]    default_seg;
  logic [7:0]    fifo_rd_data;

  logic [7:0]  fifo_mem [64];
  int          head, tail;
  logic        hold;
  logic [31:0] regs [8];
  int          n_pass = 0;
  int          n_total = 0;

  // 16-bit addressing table: base / index register per rm (-1 = none).
  int b16 [8] = '{3, 3, 5, 5, 6, 7, 5, 3};
  int i16 [8] = '{6, 7, 6, 7, -1, -1, -1, -1};

  always #5 clk = ~clk;

  assign fifo_empty   = (head == tail) || hold;
  assign fifo_rd_data = fifo_mem[head[5:0]];
  assign base_val     = regs[base_sel];
  assign index_val    = regs[index_sel];

  modrm_decoder #(.ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .flush             (flush),
    .addr32            (addr32),
    .busy              (busy),
    .complete          (complete),
    .effective_address (effective_address),
    .regnum            (regnum),
    .rm_is_reg         (rm_is_reg),
    .rm_regnum         (rm_regnum),
    .default_seg       (default_seg),
    .bytes_consumed    (bytes_consumed),
    .base_sel          (base_sel),
    .index_sel         (index_sel),
    .base_val          (base_val),
    .index_val         (index_val),
    .fifo_rd_en        (fifo_rd_en),
    .fifo_rd_data      (fifo_rd_data),
    .fifo_empty        (fifo_empty)
  );

  task automatic tick();
    logic pop;
    pop = fifo_rd_en;
    @(posedge clk);
    #1;
    if (pop) head++;
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[tail[5:0]] = b;
    tail++;
  endtask

  // Starts a decode and returns the cycle count from start to complete (-1 on timeout).
  task automatic run_decode(input bit m32, input int stall_at, input int stall_len,
                            output int lat, output int rd_in_hold);
    lat = -1;
    rd_in_hold = 0;
    start = 1'b1;
    addr32 = m32;
    tick();
    start = 1'b0;
    addr32 = ~m32;
    for (int k = 1; k <= 40; k++) begin
      hold = (k >= stall_at) && (k < stall_at + stall_len);
      #1;
      if (hold && fifo_rd_en) rd_in_hold++;
      if (complete) begin
        lat = k;
        break;
      end
      tick();
    end
    hold = 1'b0;
    tick();
  endtask

  // Reference: address rules evaluated with plain integer arithmetic.
  task automatic model(input bit m32, input logic [7:0] modrm, input logic [7:0] sib,
                       input logic [31:0] dispv, output logic [31:0] ea,
                       output logic [1:0] seg, output int dlen, output bit has_sib);
    int md, rm, base, idx, scale;
    longint sum, msk;
    md = int'(modrm[7:6]);
    rm = int'(modrm[2:0]);
    has_sib = 1'b0;
    seg = 2'd3;
    ea = 32'd0;
    dlen = 0;
    if (md == 3) return;
    if (!m32) begin
      msk = 64'hFFFF;
      base = b16[rm];
      idx = i16[rm];
      scale = 1;
      if (md == 0 && rm == 6) base = -1;
      dlen = (md == 1) ? 1 : (md == 2) ? 2 : (rm == 6) ? 2 : 0;
    end else begin
      msk = 64'hFFFF_FFFF;
      has_sib = (rm == 4);
      base = has_sib ? int'(sib[2:0]) : rm;
      idx = (has_sib && sib[5:3] != 3'd4) ? int'(sib[5:3]) : -1;
      scale = has_sib ? (1 << sib[7:6]) : 1;
      if (md == 0 && base == 5) begin
        base = -1;
        dlen = 4;
      end else begin
        dlen = (md == 1) ? 1 : (md == 2) ? 4 : 0;
      end
    end
    sum = 0;
    if (base >= 0) sum += longint'(regs[base]) & msk;
    if (idx >= 0)  sum += (longint'(regs[idx]) & msk) * scale;
    if (dlen == 1)      sum += longint'($signed(dispv[7:0]));
    else if (dlen == 2) sum += longint'(dispv[15:0]);
    else if (dlen == 4) sum += longint'(dispv);
    ea = 32'(sum & msk);
    if (base == 5 || (m32 && base == 4)) seg = 2'd2;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; addr32 = 1'b0; hold = 1'b0;
    head = 0; tail = 0;
    for (int i = 0; i < 8; i++) regs[i] = 32'd0;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (complete !== 1'b0) $display("FAIL reset_complete: got %b want 0", complete); else n_pass++;
    n_total++; if (effective_address !== 32'd0) $display("FAIL reset_ea: got %h want 0", effective_address); else n_pass++;
    n_total++; if (default_seg !== 2'd3) $display("FAIL reset_seg: got %0d want 3", default_seg); else n_pass++;
    n_total++; if (bytes_consumed !== 3'd0) $display("FAIL reset_bytes: got %0d want 0", bytes_consumed); else n_pass++;
    n_total++; if (base_sel !== 3'd0 || rm_is_reg !== 1'b0) $display("FAIL reset_sel: got %0d/%b want 0/0", base_sel, rm_is_reg); else n_pass++;
  endtask

  task automatic test_mode16();
    int lat, rdh;
    regs[5] = 32'h0000_1000;
    push(8'h46); push(8'hFE);
    run_decode(1'b0, 0, 0, lat, rdh);
    n_total++; if (lat !== 4) $display("FAIL bp_disp8_latency: got %0d want 4", lat); else n_pass++;
    n_total++; if (effective_address !== 32'h0000_0FFE) $display("FAIL bp_disp8_ea: got %h want 00000ffe", effective_address); else n_pass++;
    n_total++; if (default_seg !== 2'd2) $display("FAIL bp_disp8_seg: got %0d want 2", default_seg); else n_pass++;
    n_total++; if (bytes_consumed !== 3'd2 || regnum !== 3'd0) $display("FAIL bp_disp8_bytes: got %0d/%0d want 2/0", bytes_consumed, regnum); else n_pass++;
    push(8'h06); push(8'h34); push(8'h12);
    run_decode(1'b0, 0, 0, lat, rdh);
    n_total++; if (lat !== 5) $display("FAIL direct16_latency: got %0d want 5", lat); else n_pass++;
    n_total++; if (effective_address !== 32'h0000_1234) $display("FAIL direct16_ea: got %h want 00001234", effective_address); else n_pass++;
    n_total++; if (bytes_consumed !== 3'd3 || default_seg !== 2'd3) $display("FAIL direct16_bytes: got %0d/%0d want 3/3", bytes_consumed, default_seg); else n_pass++;
  endtask

  task automatic test_sib32();
    int lat, rdh;
    regs[0] = 32'h100; regs[1] = 32'h20;
    push(8'h44); push(8'h88); push(8'h10);
    run_decode(1'b1, 0, 0, lat, rdh);
    n_total++; if (lat !== 5) $display("FAIL sib_latency: got %0d want 5", lat); else n_pass++;
    n_total++; if (effective_address !== 32'h0000_0190) $display("FAIL sib_ea: got %h want 00000190", effective_address); else n_pass++;
    n_total++; if (default_seg !== 2'd3 || bytes_consumed !== 3'd3) $display("FAIL sib_seg_bytes: got %0d/%0d want 3/3", default_seg, bytes_consumed); else n_pass++;
    n_total++; if (base_sel !== 3'd0 || index_sel !== 3'd1) $display("FAIL sib_sel: got %0d/%0d want 0/1", base_sel, index_sel); else n_pass++;
    push(8'h05); push(8'h78); push(8'h56); push(8'h34); push(8'h12);
    run_decode(1'b1, 0, 0, lat, rdh);
    n_total++; if (effective_address !== 32'h1234_5678) $display("FAIL disp32_ea: got %h want 12345678", effective_address); else n_pass++;
    n_total++; if (bytes_consumed !== 3'd5 || default_seg !== 2'd3) $display("FAIL disp32_bytes: got %0d/%0d want 5/3", bytes_consumed, default_seg); else n_pass++;
  endtask

  task automatic test_reg_form();
    int lat, rdh;
    push(8'hC3);
    run_decode(1'b1, 0, 0, lat, rdh);
    n_total++; if (lat !== 3) $display("FAIL regform_latency: got %0d want 3", lat); else n_pass++;
    n_total++; if (rm_is_reg !== 1'b1 || rm_regnum !== 3'd3 || regnum !== 3'd0) $display("FAIL regform_fields: got %b/%0d/%0d want 1/3/0", rm_is_reg, rm_regnum, regnum); else n_pass++;
    n_total++; if (effective_address !== 32'd0 || bytes_consumed !== 3'd1) $display("FAIL regform_ea: got %h/%0d want 0/1", effective_address, bytes_consumed); else n_pass++;
    regs[5] = 32'h0000_8000;
    push(8'h45); push(8'h00);
    run_decode(1'b1, 0, 0, lat, rdh);
    n_total++; if (effective_address !== 32'h0000_8000) $display("FAIL ebp_ea: got %h want 00008000", effective_address); else n_pass++;
    n_total++; if (default_seg !== 2'd2 || rm_is_reg !== 1'b0) $display("FAIL ebp_seg: got %0d/%b want 2/0", default_seg, rm_is_reg); else n_pass++;
  endtask

  task automatic test_stall();
    int lat, rdh;
    push(8'h05); push(8'h78); push(8'h56); push(8'h34); push(8'h12);
    run_decode(1'b1, 3, 3, lat, rdh);
    n_total++; if (lat !== 10) $display("FAIL stall_latency: got %0d want 10", lat); else n_pass++;
    n_total++; if (rdh !== 0) $display("FAIL stall_rd_en: got %0d pops while empty want 0", rdh); else n_pass++;
    n_total++; if (effective_address !== 32'h1234_5678) $display("FAIL stall_ea: got %h want 12345678", effective_address); else n_pass++;
  endtask

  task automatic test_flush();
    int lat, rdh, h0, seen;
    push(8'h06); push(8'h34); push(8'h12);
    run_decode(1'b0, 0, 0, lat, rdh);
    push(8'h05); push(8'h78); push(8'h56); push(8'h34); push(8'h12);
    start = 1'b1; addr32 = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    flush = 1'b1;
    #1;
    n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL flush_rd_en: got %b want 0", fifo_rd_en); else n_pass++;
    tick();
    flush = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL flush_idle: busy got %b want 0", busy); else n_pass++;
    h0 = head; seen = 0;
    for (int i = 0; i < 6; i++) begin if (complete) seen++; tick(); end
    n_total++; if (seen !== 0 || head !== h0) $display("FAIL flush_quiet: got %0d completes %0d pops want 0/0", seen, head - h0); else n_pass++;
    n_total++; if (effective_address !== 32'h0000_1234) $display("FAIL flush_hold_ea: got %h want 00001234", effective_address); else n_pass++;
    head = tail;
    regs[0] = 32'h100; regs[1] = 32'h20;
    push(8'h44); push(8'h88); push(8'h10);
    run_decode(1'b1, 0, 0, lat, rdh);
    n_total++; if (lat !== 5 || effective_address !== 32'h190) $display("FAIL flush_restart: got lat %0d ea %h want 5/00000190", lat, effective_address); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, rdh, h0, seen;
    push(8'h44); push(8'h88); push(8'h10);
    start = 1'b1; addr32 = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL rstmid_rd_en: got %b want 0", fifo_rd_en); else n_pass++;
    tick();
    reset = 1'b0;
    n_total++; if (busy !== 1'b0 || effective_address !== 32'd0 || default_seg !== 2'd3) $display("FAIL rstmid_state: got %b/%h/%0d want 0/0/3", busy, effective_address, default_seg); else n_pass++;
    h0 = head; seen = 0;
    for (int i = 0; i < 6; i++) begin if (complete) seen++; tick(); end
    n_total++; if (seen !== 0 || head !== h0) $display("FAIL rstmid_quiet: got %0d completes %0d pops want 0/0", seen, head - h0); else n_pass++;
    head = tail;
    regs[5] = 32'h0000_8000;
    push(8'h45); push(8'h00);
    run_decode(1'b1, 0, 0, lat, rdh);
    n_total++; if (lat !== 4 || effective_address !== 32'h8000 || default_seg !== 2'd2) $display("FAIL rstmid_restart: got %0d/%h/%0d want 4/00008000/2", lat, effective_address, default_seg); else n_pass++;
  endtask

  task automatic test_random();
    int lat, rdh, dlen, nb;
    bit m32, has_sib;
    logic [7:0] modrm, sib;
    logic [31:0] dispv, ea;
    logic [1:0] seg;
    for (int it = 0; it < 60; it++) begin
      m32 = 1'($urandom_range(0, 1));
      modrm = 8'($urandom);
      sib = 8'($urandom);
      dispv = $urandom;
      for (int r = 0; r < 8; r++) regs[r] = $urandom;
      model(m32, modrm, sib, dispv, ea, seg, dlen, has_sib);
      nb = 1 + int'(has_sib) + dlen;
      push(modrm);
      if (has_sib) push(sib);
      for (int b = 0; b < dlen; b++) push(dispv[8*b +: 8]);
      run_decode(m32, 0, 0, lat, rdh);
      n_total++; if (lat !== nb + 2) $display("FAIL rnd%0d_latency: got %0d want %0d", it, lat, nb + 2); else n_pass++;
      n_total++; if (effective_address !== ea) $display("FAIL rnd%0d_ea: modrm %h sib %h m32 %b got %h want %h", it, modrm, sib, m32, effective_address, ea); else n_pass++;
      n_total++; if (default_seg !== seg) $display("FAIL rnd%0d_seg: got %0d want %0d", it, default_seg, seg); else n_pass++;
      n_total++; if (bytes_consumed !== 3'(nb)) $display("FAIL rnd%0d_bytes: got %0d want %0d", it, bytes_consumed, nb); else n_pass++;
      n_total++; if (regnum !== modrm[5:3] || rm_regnum !== modrm[2:0] || rm_is_reg !== (modrm[7:6] == 2'b11))
        $display("FAIL rnd%0d_fields: got %0d/%0d/%b want %0d/%0d/%b", it, regnum, rm_regnum, rm_is_reg, modrm[5:3], modrm[2:0], modrm[7:6] == 2'b11);
      else n_pass++;
      head = tail;
    end
  endtask

  initial begin
    test_reset();
    test_mode16();
    test_sib32();
    test_reg_form();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_total);
    $fatal(1);
  end

endmodule

`default_nettype wire
